// File: rtl/odd_par_pkg.sv
// Shared definitions for the odd-parity generator/checker.
//   DATA_W   : protected data width (nibble)
//   CODE_W   : codeword width, data plus one parity bit
//   code_t   : codeword type {data[3:0], parity}
//   CODE_RST : codeword held in reset (data 0000 with its odd-parity bit)
//   odd_par  : returns the bit that makes {data, bit} odd weight
package odd_par_pkg;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned CODE_W = DATA_W + 1;

  typedef logic [CODE_W-1:0] code_t;

  localparam code_t CODE_RST = 5'b00001;

  function automatic logic odd_par(input logic [DATA_W-1:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/odd_par_tree.sv
// Combinational XNOR reduction over a configurable width.
//   Width  : number of input bits
//   data_i : bits to reduce
//   xnor_o : 1 when data_i has an even number of ones
// Over a data nibble this is the odd-parity bit; over a full codeword it is the
// error flag (even weight means the codeword is corrupt).
module odd_par_tree #(
  parameter int unsigned Width = 4
) (
  input  logic [Width-1:0] data_i,
  output logic             xnor_o
);

  assign xnor_o = ~^data_i;

endmodule

// File: rtl/odd_parity_gen_4bit.sv
// Registered odd-parity generator for a 4-bit nibble with optional checker.
// Optional checker is compiled in with macro ODD_PAR_CHECK_EN.
//   ERR_CNT_W : width of the saturating error counter (checker only)
//   clk       : clock, rising edge
//   rst_n     : synchronous active-low reset
//   in_valid  : i is valid this cycle
//   i         : data nibble to protect
//   p         : registered odd-parity bit of the last accepted nibble
//   code_out  : registered codeword {i, p}
//   out_valid : p/code_out were loaded on the last edge
//   rx_valid  : rx_code is valid this cycle (checker only)
//   rx_code   : received codeword {data, parity} (checker only)
//   rx_err    : registered even-weight flag for the last rx_code (checker only)
//   err_cnt   : saturating count of errored codewords (checker only)
module odd_parity_gen_4bit
  import odd_par_pkg::*;
#(
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [DATA_W-1:0]    i,
`ifdef ODD_PAR_CHECK_EN
  input  logic                 rx_valid,
  input  logic [CODE_W-1:0]    rx_code,
  output logic                 rx_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
`endif
  output logic                 p,
  output logic [CODE_W-1:0]    code_out,
  output logic                 out_valid
);

  logic  p_d;
  logic  p_q;
  code_t code_q;
  logic  out_valid_q;

  odd_par_tree #(
    .Width (DATA_W)
  ) u_gen_tree (
    .data_i (i),
    .xnor_o (p_d)
  );

  // Reset overrides any valid input presented on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_q         <= CODE_RST[0];
      code_q      <= CODE_RST;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        p_q    <= p_d;
        code_q <= {i, p_d};
      end
    end
  end

  assign p         = p_q;
  assign code_out  = code_q;
  assign out_valid = out_valid_q;

`ifdef ODD_PAR_CHECK_EN
  logic                 rx_err_d;
  logic                 rx_err_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  // Even weight over the whole codeword means a corrupt word.
  odd_par_tree #(
    .Width (CODE_W)
  ) u_chk_tree (
    .data_i (rx_code),
    .xnor_o (rx_err_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_err_q  <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      rx_err_q <= rx_valid & rx_err_d;
      if (rx_valid && rx_err_d && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
        err_cnt_q <= err_cnt_q + 1'b1;
      end
    end
  end

  assign rx_err  = rx_err_q;
  assign err_cnt = err_cnt_q;
`else
  // Counter width only matters when the checker is present.
  logic unused_err_cnt_w;
  assign unused_err_cnt_w = ^ERR_CNT_W;
`endif

endmodule

// File: tb/tb_odd_parity_gen_4bit.sv
// Scoreboard bench for odd_parity_gen_4bit. Expected codewords/error flags are
// queued when stimulus is issued and popped by a monitor on the falling edge.
module tb_odd_parity_gen_4bit;

  localparam int unsigned CntW   = 2;
  localparam int          CntMax = (1 << CntW) - 1;

  typedef struct {
    int         due;
    logic [4:0] code;
  } gen_exp_t;

  typedef struct {
    int   due;
    logic err;
  } rx_exp_t;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic [3:0]      i;
  logic            p;
  logic [4:0]      code_out;
  logic            out_valid;
  logic            rx_valid;
  logic [4:0]      rx_code;
  logic            rx_err;
  logic [CntW-1:0] err_cnt;

  gen_exp_t gq[$];
  rx_exp_t  rq[$];
  int       cyc;
  logic     rst_at_edge;
  logic     started;
  logic [4:0] last_code;
  int       cnt_model;
  int       checks;
  int       failures;

  odd_parity_gen_4bit #(
    .ERR_CNT_W (CntW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .i         (i),
`ifdef ODD_PAR_CHECK_EN
    .rx_valid  (rx_valid),
    .rx_code   (rx_code),
    .rx_err    (rx_err),
    .err_cnt   (err_cnt),
`endif
    .p         (p),
    .code_out  (code_out),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc         = 0;
    rst_at_edge = 1'b0;
  end

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= !rst_n;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // Reference: parity bit is 1 exactly when the nibble has an even count of ones.
  function automatic logic [4:0] ref_code(input logic [3:0] d);
    return {d, ($countones(d) % 2 == 0) ? 1'b1 : 1'b0};
  endfunction

  // Apply one cycle of stimulus; lb loops the current generator output into rx.
  task automatic step(input logic rn, input logic iv, input logic [3:0] d,
                      input logic rv, input logic [4:0] rc, input bit lb);
    gen_exp_t ge;
    rx_exp_t  re;
    @(posedge clk);
    #1;
    rst_n    = rn;
    in_valid = iv;
    i        = d;
    if (lb) begin
      rx_valid = out_valid;
      rx_code  = code_out;
    end else begin
      rx_valid = rv;
      rx_code  = rc;
    end
    if (rn && iv) begin
      ge.due  = cyc + 1;
      ge.code = ref_code(d);
      gq.push_back(ge);
    end
`ifdef ODD_PAR_CHECK_EN
    if (rn && rx_valid) begin
      re.due = cyc + 1;
      re.err = ($countones(rx_code) % 2 == 0);
      rq.push_back(re);
    end
`endif
  endtask

  // Monitor / scoreboard.
  initial begin
    started   = 1'b0;
    last_code = 5'b00001;
    cnt_model = 0;
  end

  always @(negedge clk) begin
    gen_exp_t ge;
    rx_exp_t  re;
    logic     exp_v;
    logic     exp_err;
    if (rst_at_edge) begin
      started = 1'b1;
      while (gq.size() > 0 && gq[0].due <= cyc) ge = gq.pop_front();
      while (rq.size() > 0 && rq[0].due <= cyc) re = rq.pop_front();
      last_code = 5'b00001;
      cnt_model = 0;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_code_out", 32'(code_out), 32'h01);
      check("rst_p", 32'(p), 32'd1);
`ifdef ODD_PAR_CHECK_EN
      check("rst_rx_err", 32'(rx_err), 32'd0);
      check("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
    end else if (started) begin
      exp_v = (gq.size() > 0) && (gq[0].due == cyc);
      check("out_valid", 32'(out_valid), 32'(exp_v));
      if (exp_v) begin
        ge        = gq.pop_front();
        last_code = ge.code;
      end
      check("code_out", 32'(code_out), 32'(last_code));
      check("p", 32'(p), 32'(last_code[0]));
      if (out_valid) check("code_weight_odd", 32'($countones(code_out) % 2), 32'd1);
`ifdef ODD_PAR_CHECK_EN
      exp_err = 1'b0;
      if ((rq.size() > 0) && (rq[0].due == cyc)) begin
        re      = rq.pop_front();
        exp_err = re.err;
      end
      if (exp_err && cnt_model < CntMax) cnt_model++;
      check("rx_err", 32'(rx_err), 32'(exp_err));
      check("err_cnt", 32'(err_cnt), 32'(cnt_model));
`endif
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] dir[4];
    dir[0] = 4'b0010;
    dir[1] = 4'b0011;
    dir[2] = 4'b0111;
    dir[3] = 4'b1111;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    i        = 4'b1111;
    rx_valid = 1'b0;
    rx_code  = 5'b0;

    // Reset held two edges with valid input present.
    step(1'b0, 1'b1, 4'b1111, 1'b1, 5'b00110, 1'b0);
    step(1'b0, 1'b1, 4'b1111, 1'b1, 5'b00110, 1'b0);

    // Directed nibbles back-to-back.
    foreach (dir[k]) step(1'b1, 1'b1, dir[k], 1'b0, 5'b0, 1'b0);

    // Hold: data toggles while invalid.
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 4'($urandom), 1'b0, 5'b0, 1'b0);

    // All 16 nibbles back-to-back.
    for (int k = 0; k < 16; k++) step(1'b1, 1'b1, 4'(k), 1'b0, 5'b0, 1'b0);

    // Random traffic on the generator.
    for (int k = 0; k < 40; k++)
      step(1'b1, 1'($urandom), 4'($urandom), 1'b0, 5'b0, 1'b0);

    // Mid-stream reset with valid input on the reset edge.
    step(1'b1, 1'b1, 4'b0101, 1'b0, 5'b0, 1'b0);
    step(1'b0, 1'b1, 4'b1000, 1'b0, 5'b0, 1'b0);
    step(1'b1, 1'b1, 4'b1001, 1'b0, 5'b0, 1'b0);

    // Checker: clean word, errored word, then generator loopback.
    step(1'b1, 1'b0, 4'b0, 1'b1, 5'b00111, 1'b0);
    step(1'b1, 1'b0, 4'b0, 1'b1, 5'b00110, 1'b0);
    step(1'b1, 1'b0, 4'b0, 1'b0, 5'b0, 1'b0);
    for (int k = 0; k < 12; k++) step(1'b1, 1'b1, 4'($urandom), 1'b0, 5'b0, 1'b1);

    // Reset, then saturate the counter with five errored words and reset mid-burst.
    step(1'b0, 1'b0, 4'b0, 1'b0, 5'b0, 1'b0);
    for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 4'($urandom), 1'b1, 5'b00110, 1'b0);
    step(1'b1, 1'b0, 4'b0, 1'b1, 5'b11000, 1'b0);
    step(1'b0, 1'b1, 4'b0110, 1'b1, 5'b00110, 1'b0);

    // Random traffic on both paths simultaneously.
    for (int k = 0; k < 40; k++)
      step(1'b1, 1'($urandom), 4'($urandom), 1'($urandom), 5'($urandom), 1'b0);

    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 4'b0, 1'b0, 5'b0, 1'b0);
    @(negedge clk);
    check("gen_queue_drained", 32'(gq.size()), 32'd0);
    check("rx_queue_drained", 32'(rq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
